alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_dispatch_fifo.sv | 39 +++
 rtl/alu_dispatch.sv | 95 +++++++++
 tb/tb_alu_dispatch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and the instruction record for the ALU dispatch block.
package alu_pkg;
  localparam int N = 32;
  localparam int REG_W = 3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_PACK = 4'b1101;

  typedef struct packed {
    logic [3:0]       op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } instr_t;

  localparam int INSTR_W = $bits(instr_t);
endpackage

// File: rtl/alu_dispatch_fifo.sv
// Synchronous FIFO; the extra pointer bit separates full from empty.
module alu_dispatch_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/alu_dispatch.sv
// Instruction FIFO -> EXEC operand register -> WB record, with register file and EXEC bypass.
// Handshakes: a transfer happens on an edge where valid && ready; valid never waits on ready.
module alu_dispatch #(
  parameter int N     = alu_pkg::N,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [2:0]   in_rs,
  input  logic [2:0]   in_rt,
  input  logic [2:0]   in_rd,
  output logic [N-1:0] alu_inA,
  output logic [N-1:0] alu_inB,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_out,
  input  logic         alu_zero,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [2:0]   wb_rd,
  output logic [N-1:0] wb_data,
  output logic         wb_zero,
  input  logic [2:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);
  import alu_pkg::*;

  logic [N-1:0] regs [8];
  instr_t       head;
  instr_t       wr_instr;
  logic         full, empty, push, pop, advance;
  logic         exec_valid;
  logic [2:0]   exec_rd;
  logic [N-1:0] opa, opb;

  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign advance  = !(wb_valid && !wb_ready);
  assign pop      = advance && !empty;
  assign wr_instr = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd};
  assign dbg_data = regs[dbg_addr];

  alu_dispatch_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_instr),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // The EXEC result is written on the same edge the next instruction issues, so forward it.
  always_comb begin
    opa = regs[head.rs];
    opb = regs[head.rt];
    if (exec_valid && exec_rd == head.rs && head.rs != '0) opa = alu_out;
    if (exec_valid && exec_rd == head.rt && head.rt != '0) opb = alu_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exec_valid <= 1'b0;
      exec_rd    <= '0;
      alu_inA    <= '0;
      alu_inB    <= '0;
      alu_op     <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_zero    <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (advance) begin
      if (!empty) begin
        alu_inA    <= opa;
        alu_inB    <= opb;
        alu_op     <= head.op;
        exec_rd    <= head.rd;
        exec_valid <= 1'b1;
      end else begin
        exec_valid <= 1'b0;
      end
      wb_valid <= exec_valid;
      if (exec_valid) begin
        wb_rd   <= exec_rd;
        wb_data <= alu_out;
        wb_zero <= alu_zero;
        if (exec_rd != '0) regs[exec_rd] <= alu_out;
      end
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural ALU and a writeback record queue.
module tb_alu_dispatch;
  import alu_pkg::*;

  localparam int W = 3 + N + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = '0;
  logic [2:0]   in_rs = '0, in_rt = '0, in_rd = '0;
  logic [N-1:0] alu_inA, alu_inB, alu_out;
  logic [3:0]   alu_op;
  logic         alu_zero;
  logic         wb_valid;
  logic         wb_ready = 1'b1;
  logic [2:0]   wb_rd;
  logic [N-1:0] wb_data;
  logic         wb_zero;
  logic [2:0]   dbg_addr = '0;
  logic [N-1:0] dbg_data;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] seed_val = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  alu_dispatch #(.N(N), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_zero(wb_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU; unknown opcodes return seed_val so registers can be loaded.
  always_comb begin
    case (alu_op)
      OP_AND:  alu_out = alu_inA & alu_inB;
      OP_OR:   alu_out = alu_inA | alu_inB;
      OP_ADD:  alu_out = alu_inA + alu_inB;
      OP_SUB:  alu_out = alu_inA - alu_inB;
      OP_SLT:  alu_out = N'($signed(alu_inA) < $signed(alu_inB));
      OP_NOR:  alu_out = ~(alu_inA | alu_inB);
      OP_PACK: alu_out = {alu_inA[N/2-1:0], alu_inB[N/2-1:0]};
      default: alu_out = seed_val;
    endcase
    alu_zero = (alu_out == '0);
  end

  // Record every writeback accepted at the following rising edge.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) obs_q.push_back({wb_rd, wb_data, wb_zero});
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL issue_timeout op=%0h rd=%0d got=not_accepted exp=accepted", op, rd);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [N-1:0] v);
    dbg_addr = a;
    @(negedge clk);
    v = dbg_data;
    step();
  endtask

  task automatic seed(input logic [2:0] rd, input logic [N-1:0] val);
    seed_val = val;
    issue(4'hF, 3'd0, 3'd0, rd);
    repeat (3) step();
    obs_q.delete();
  endtask

  // Scenarios
  task automatic test_reset();
    logic [N-1:0] v;
    rst = 1'b1;
    in_valid = 1'b1; in_op = OP_ADD; in_rs = 3'd0; in_rt = 3'd0; in_rd = 3'd1;
    step(); step();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
    checks++;
    if (alu_op !== 4'h0 || alu_inA !== '0) begin
      failures++; $display("FAIL reset_alu got_op=%0h got_a=%0h exp=0", alu_op, alu_inA);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    seed(3'd1, 32'd5);
    read_reg(3'd1, v);
    checks++;
    if (v !== 32'd5) begin failures++; $display("FAIL seed_r1 got=%0h exp=5", v); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_again_wb_valid got=%0b exp=0", wb_valid); end
    read_reg(3'd1, v);
    checks++;
    if (v !== '0) begin failures++; $display("FAIL rst_clears_r1 got=%0h exp=0", v); end
  endtask

  task automatic test_sub_latency();
    logic [N-1:0] v;
    seed(3'd1, 32'd7);
    seed(3'd2, 32'd3);
    issue(OP_SUB, 3'd1, 3'd2, 3'd3);
    step();
    checks++;
    if (alu_op !== OP_SUB || alu_inA !== 32'd7 || alu_inB !== 32'd3) begin
      failures++;
      $display("FAIL sub_exec got_op=%0h a=%0h b=%0h exp_op=6 a=7 b=3", alu_op, alu_inA, alu_inB);
    end
    checks++;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL sub_wb_early got=%0b exp=0", wb_valid); end
    step();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 32'd4 || wb_zero !== 1'b0) begin
      failures++;
      $display("FAIL sub_wb got v=%0b rd=%0d d=%0h z=%0b exp v=1 rd=3 d=4 z=0",
               wb_valid, wb_rd, wb_data, wb_zero);
    end
    dbg_addr = 3'd3;
    #1;
    checks++;
    if (dbg_data !== 32'd4) begin failures++; $display("FAIL sub_r3 got=%0h exp=4", dbg_data); end
    repeat (2) step();
    obs_q.delete();
    v = '0;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] v;
    logic [W-1:0] got, exp;
    exp_q.delete(); obs_q.delete();
    issue(OP_ADD,  3'd1, 3'd2, 3'd4); exp_q.push_back({3'd4, 32'd10, 1'b0});
    issue(OP_AND,  3'd4, 3'd4, 3'd5); exp_q.push_back({3'd5, 32'd10, 1'b0});
    issue(OP_OR,   3'd1, 3'd2, 3'd6); exp_q.push_back({3'd6, 32'd7, 1'b0});
    issue(OP_SLT,  3'd2, 3'd1, 3'd7); exp_q.push_back({3'd7, 32'd1, 1'b0});
    issue(OP_NOR,  3'd1, 3'd2, 3'd6); exp_q.push_back({3'd6, 32'hFFFF_FFF8, 1'b0});
    issue(OP_PACK, 3'd1, 3'd2, 3'd7); exp_q.push_back({3'd7, 32'h0007_0003, 1'b0});
    issue(OP_SLT,  3'd1, 3'd2, 3'd3); exp_q.push_back({3'd3, 32'd0, 1'b1});
    repeat (6) step();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = obs_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL b2b_record got=%0h exp=%0h", got, exp); end
    end
    read_reg(3'd5, v);
    checks++;
    if (v !== 32'd10) begin failures++; $display("FAIL bypass_r5 got=%0h exp=a", v); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got, exp;
    bit ok;
    exp_q.delete(); obs_q.delete();
    wb_ready = 1'b0;
    // One record parks in WB, one in EXEC, four fill the FIFO.
    issue(OP_ADD,  3'd1, 3'd2, 3'd3); exp_q.push_back({3'd3, 32'd10, 1'b0});
    issue(OP_SUB,  3'd1, 3'd2, 3'd4); exp_q.push_back({3'd4, 32'd4, 1'b0});
    issue(OP_OR,   3'd1, 3'd2, 3'd5); exp_q.push_back({3'd5, 32'd7, 1'b0});
    issue(OP_AND,  3'd1, 3'd2, 3'd6); exp_q.push_back({3'd6, 32'd3, 1'b0});
    issue(OP_SLT,  3'd2, 3'd1, 3'd7); exp_q.push_back({3'd7, 32'd1, 1'b0});
    issue(OP_PACK, 3'd1, 3'd2, 3'd3); exp_q.push_back({3'd3, 32'h0007_0003, 1'b0});
    in_valid = 1'b1; in_op = OP_NOR; in_rs = 3'd1; in_rt = 3'd2; in_rd = 3'd4;
    exp_q.push_back({3'd4, 32'hFFFF_FFF8, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full cyc=%0d got=%0b exp=0", i, in_ready); end
      step();
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 32'd10) begin
      failures++; $display("FAIL bp_hold got v=%0b rd=%0d d=%0h exp v=1 rd=3 d=a", wb_valid, wb_rd, wb_data);
    end
    wb_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; step(); break; end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_release got=not_accepted exp=accepted"); end
    repeat (12) step();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = obs_q.pop_front();
      checks++;
      if (got !== exp) begin failures++; $display("FAIL bp_record got=%0h exp=%0h", got, exp); end
    end
  endtask

  task automatic test_r0_write();
    logic [N-1:0] v;
    issue(OP_ADD, 3'd1, 3'd2, 3'd0);
    step(); step();
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd0 || wb_data !== 32'd10) begin
      failures++; $display("FAIL r0_wb got v=%0b rd=%0d d=%0h exp v=1 rd=0 d=a", wb_valid, wb_rd, wb_data);
    end
    read_reg(3'd0, v);
    checks++;
    if (v !== '0) begin failures++; $display("FAIL r0_stays_zero got=%0h exp=0", v); end
    repeat (2) step();
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] v;
    obs_q.delete();
    wb_ready = 1'b0;
    issue(OP_ADD, 3'd1, 3'd2, 3'd3);
    issue(OP_ADD, 3'd1, 3'd2, 3'd4);
    issue(OP_ADD, 3'd1, 3'd2, 3'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || alu_op !== 4'h0 || alu_inA !== '0) begin
      failures++; $display("FAIL mid_reset_pipe got v=%0b op=%0h a=%0h exp 0", wb_valid, alu_op, alu_inA);
    end
    wb_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), v);
      checks++;
      if (v !== '0) begin failures++; $display("FAIL mid_reset_reg r%0d got=%0h exp=0", r, v); end
    end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL mid_reset_dropped got=%0d exp=0", obs_q.size()); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%0b exp=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_sub_latency();
    test_back_to_back();
    test_backpressure();
    test_r0_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
